// File: rtl/seq_match_ctrl_if.sv
// Handshake bundle for seq_match_ctrl: command, serial bit and result.
// master drives cmd/bit/abort/res_ready; slave (the controller) drives the rest.
interface seq_match_ctrl_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [PAT_W-1:0] cmd_pattern;
  logic [LEN_W-1:0] cmd_len;
  logic             bit_valid;
  logic             bit_i;
  logic             bit_ready;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_cnt;
  logic             res_of;
  logic             busy;

  modport master (
    output cmd_valid, cmd_pattern, cmd_len,
    output bit_valid, bit_i, abort, res_ready,
    input  cmd_ready, bit_ready, res_valid,
    input  res_cnt, res_of, busy
  );

  modport slave (
    input  cmd_valid, cmd_pattern, cmd_len,
    input  bit_valid, bit_i, abort, res_ready,
    output cmd_ready, bit_ready, res_valid,
    output res_cnt, res_of, busy
  );
endinterface

// File: rtl/seq_match_ctrl.sv
// Serial pattern matcher: counts pattern hits over a bit window.
// Ports: clk, rst (sync, active-high), bus (seq_match_ctrl_if.slave).
// Macro SEQ_MATCH_OVERLAP_EN: keep history after a hit (overlapping).
module seq_match_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = 16
) (
  input logic            clk,
  input logic            rst,
  seq_match_ctrl_if.slave bus
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             of_q, of_d;

  logic [PAT_W-1:0] hist_n;
  logic [FW-1:0]    fill_n;
  logic             match;

  always_comb begin
    hist_n = PAT_W'({hist_q, bus.bit_i});
    fill_n = (fill_q == FULL) ? FULL
                              : fill_q + FW'(1);
    match  = (fill_n == FULL) &&
             (hist_n == pat_q);

    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    of_d    = of_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pat_d   = bus.cmd_pattern;
          rem_d   = bus.cmd_len;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
          of_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.bit_valid) begin
          hist_d = hist_n;
`ifdef SEQ_MATCH_OVERLAP_EN
          fill_d = fill_n;
`else
          fill_d = match ? '0 : fill_n;
`endif
          // rem 0 wraps, giving a 2^LEN_W window
          rem_d = rem_q - LEN_W'(1);
          if (match && !of_q) begin
            if (cnt_q == CMAX) of_d = 1'b1;
            else cnt_d = cnt_q + CNT_W'(1);
          end
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      of_q    <= of_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.bit_ready = (state_q == RUN);
  assign bus.res_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_cnt   = cnt_q;
  assign bus.res_of    = of_q;

endmodule
